// File: rtl/kiana_rf_pkg.sv
// Shared types for the register-file read arbiter: operand field widths and
// the sequencer state encoding.
package kiana_rf_pkg;

    typedef logic [4:0]  warp_id_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] rf_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rf_arb_state_t;

endpackage

// File: rtl/rf_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. The pointer itself is owned by the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        // Scan from the farthest slot back so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = IW'(idx);
            end
        end
        if (en && (|req)) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin operand-fetch sequencer for the shared register-file read ports.
// Optional WAIT watchdog enabled by defining RF_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; grant pulses req_ready and latches the slot's fields
// ISSUE | one-cycle rf_req pulse on each enabled port
// WAIT  | collect per-port read data until both ports are done
// RESP  | hold the tagged response until resp_ready
module rf_read_arbiter
    import kiana_rf_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ*5-1:0]                       req_warp_id,
    input  logic [NUM_REQ*5-1:0]                       req_rs1,
    input  logic [NUM_REQ*5-1:0]                       req_rs2,
    input  logic [NUM_REQ-1:0]                         req_rs1_en,
    input  logic [NUM_REQ-1:0]                         req_rs2_en,
    output logic [4:0]                                 rf_warp_id,
    output logic [4:0]                                 rf_addr_1,
    output logic [4:0]                                 rf_addr_2,
    output logic                                       rf_req_1,
    output logic                                       rf_req_2,
    input  logic                                       rf_data_valid_1,
    input  logic                                       rf_data_valid_2,
    input  logic [31:0]                                rf_data_1,
    input  logic [31:0]                                rf_data_2,
    output logic                                       resp_valid,
    input  logic                                       resp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] resp_id,
    output logic [31:0]                                resp_data_1,
    output logic [31:0]                                resp_data_2,
    output logic                                       err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rf_arb_state_t state, state_nxt;

    logic [IW-1:0]      ptr, gnt_idx, id_q;
    logic [NUM_REQ-1:0] gnt;
    logic               arb_en;
    warp_id_t           warp_q;
    reg_addr_t          rs1_q, rs2_q;
    logic               en1_q, en2_q, done1, done2;
    rf_data_t           data1_q, data2_q;
    logic               err_q;
    logic               grant, cap1, cap2, spurious, timeout_hit;
    logic               en1_sel, en2_sel;

`ifdef RF_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
`endif

    assign arb_en = (state == IDLE);

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign en1_sel = req_rs1_en[gnt_idx];
    assign en2_sel = req_rs2_en[gnt_idx];

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        cap1        = 1'b0;
        cap2        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    grant     = 1'b1;
                    state_nxt = (en1_sel || en2_sel) ? ISSUE : RESP;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                cap1 = rf_data_valid_1 && !done1;
                cap2 = rf_data_valid_2 && !done2;
                if ((done1 || cap1) && (done2 || cap2)) begin
                    state_nxt = RESP;
                end
`ifdef RF_ARB_TIMEOUT_EN
                else if (wait_cnt + 8'd1 == TIMEOUT_LIM) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
`endif
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Any read data not claimed by an open WAIT slot is a protocol error.
        spurious = (rf_data_valid_1 && !((state == WAIT) && !done1)) ||
                   (rf_data_valid_2 && !((state == WAIT) && !done2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            warp_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            done1   <= 1'b0;
            done2   <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                ptr     <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                id_q    <= gnt_idx;
                warp_q  <= req_warp_id[int'(gnt_idx)*5 +: 5];
                rs1_q   <= req_rs1[int'(gnt_idx)*5 +: 5];
                rs2_q   <= req_rs2[int'(gnt_idx)*5 +: 5];
                en1_q   <= en1_sel;
                en2_q   <= en2_sel;
                done1   <= !en1_sel;
                done2   <= !en2_sel;
                data1_q <= '0;
                data2_q <= '0;
            end
            if (cap1) begin
                data1_q <= rf_data_1;
                done1   <= 1'b1;
            end
            if (cap2) begin
                data2_q <= rf_data_2;
                done2   <= 1'b1;
            end
            if (spurious || timeout_hit) err_q <= 1'b1;
        end
    end

`ifdef RF_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

    assign req_ready   = gnt;
    assign rf_warp_id  = warp_q;
    assign rf_addr_1   = rs1_q;
    assign rf_addr_2   = rs2_q;
    assign rf_req_1    = (state == ISSUE) && en1_q;
    assign rf_req_2    = (state == ISSUE) && en2_q;
    assign resp_valid  = (state == RESP);
    assign resp_id     = id_q;
    assign resp_data_1 = data1_q;
    assign resp_data_2 = data2_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Self-checking bench for rf_read_arbiter: directed vector table, randomized
// transactions against a timing model, and reset/error/fairness sequences.
module tb_rf_read_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_rs1_en, req_rs2_en;
    logic [N*5-1:0] req_warp_id, req_rs1, req_rs2;
    logic [4:0]     rf_warp_id, rf_addr_1, rf_addr_2;
    logic           rf_req_1, rf_req_2, rf_data_valid_1, rf_data_valid_2;
    logic [31:0]    rf_data_1, rf_data_2, resp_data_1, resp_data_2;
    logic           resp_valid, resp_ready, err;
    logic [1:0]     resp_id;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    rf_read_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_warp_id(req_warp_id), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_rs1_en(req_rs1_en), .req_rs2_en(req_rs2_en),
        .rf_warp_id(rf_warp_id), .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
        .rf_req_1(rf_req_1), .rf_req_2(rf_req_2),
        .rf_data_valid_1(rf_data_valid_1), .rf_data_valid_2(rf_data_valid_2),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data_1(resp_data_1), .resp_data_2(resp_data_2), .err(err)
    );

    typedef struct {
        logic [3:0]  vec;
        int          slot;
        logic [4:0]  warp, rs1, rs2;
        logic        en1, en2;
        int          d1, d2, stall;
        logic [31:0] data1, data2;
        int          lat;
    } txn_t;

    txn_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Round-robin rule: first valid slot at or after the pointer.
    function automatic int rr_pick(input logic [3:0] vec, input int p);
        for (int k = 0; k < N; k++) begin
            if (vec[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Response cycle relative to grant: rf_req at +1, data at +1+d, response the cycle after the last capture.
    function automatic int spec_latency(input logic e1, input logic e2, input int d1, input int d2);
        int last;
        last = 0;
        if (!e1 && !e2) return 1;
        if (e1 && (d1 + 1) > last) last = d1 + 1;
        if (e2 && (d2 + 1) > last) last = d2 + 1;
        return last + 1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; rf_data_valid_1 = 1'b0; rf_data_valid_2 = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mptr = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rf_req_1"}, 32'(rf_req_1), 32'd0);
        chk({tag, "_rf_req_2"}, 32'(rf_req_2), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rf_warp_id"}, 32'(rf_warp_id), 32'd0);
        chk({tag, "_rf_addr_1"}, 32'(rf_addr_1), 32'd0);
        chk({tag, "_rf_addr_2"}, 32'(rf_addr_2), 32'd0);
        chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_resp_data_1"}, resp_data_1, 32'd0);
        chk({tag, "_resp_data_2"}, resp_data_2, 32'd0);
    endtask

    task automatic present(input txn_t t);
        req_warp_id = 20'($urandom); req_rs1 = 20'($urandom); req_rs2 = 20'($urandom);
        req_rs1_en = 4'($urandom); req_rs2_en = 4'($urandom);
        req_warp_id[t.slot*5 +: 5] = t.warp;
        req_rs1[t.slot*5 +: 5]     = t.rs1;
        req_rs2[t.slot*5 +: 5]     = t.rs2;
        req_rs1_en[t.slot]         = t.en1;
        req_rs2_en[t.slot]         = t.en2;
        req_valid  = t.vec;
        resp_ready = 1'b0;
        rf_data_valid_1 = 1'b0; rf_data_valid_2 = 1'b0;
    endtask

    // One full transaction; the grant is expected in the cycle the request is presented.
    task automatic do_txn(input txn_t t);
        int hs;
        hs = t.lat + t.stall;
        present(t);
        #1;
        chk("grant", 32'(req_ready), 32'(1) << t.slot);
        for (int c = 1; c <= hs + 1; c++) begin
            @(negedge clk);
            req_valid = '0;
            rf_data_valid_1 = t.en1 && (c == 1 + t.d1);
            rf_data_valid_2 = t.en2 && (c == 1 + t.d2);
            rf_data_1 = rf_data_valid_1 ? t.data1 : $urandom;
            rf_data_2 = rf_data_valid_2 ? t.data2 : $urandom;
            resp_ready = (c >= hs);
            #1;
            chk("rf_req_1", 32'(rf_req_1), 32'(c == 1 && t.en1));
            chk("rf_req_2", 32'(rf_req_2), 32'(c == 1 && t.en2));
            if (c == 1 && (t.en1 || t.en2)) chk("rf_warp_id", 32'(rf_warp_id), 32'(t.warp));
            if (c == 1 && t.en1) chk("rf_addr_1", 32'(rf_addr_1), 32'(t.rs1));
            if (c == 1 && t.en2) chk("rf_addr_2", 32'(rf_addr_2), 32'(t.rs2));
            chk("resp_valid", 32'(resp_valid), 32'(c >= t.lat && c <= hs));
            if (c >= t.lat && c <= hs) begin
                chk("resp_id", 32'(resp_id), 32'(t.slot));
                chk("resp_data_1", resp_data_1, t.en1 ? t.data1 : 32'd0);
                chk("resp_data_2", resp_data_2, t.en2 ? t.data2 : 32'd0);
            end
        end
        rf_data_valid_1 = 1'b0; rf_data_valid_2 = 1'b0; resp_ready = 1'b0;
        mptr = (t.slot + 1) % N;
    endtask

    initial begin
        txn_t t;
        int gcyc[8];
        int gidx[8];
        int ng;
        logic pv1, pv2;
        int exp_slots[5];

        rst_n = 1'b0;
        req_valid = '0; req_warp_id = '0; req_rs1 = '0; req_rs2 = '0;
        req_rs1_en = '0; req_rs2_en = '0;
        rf_data_valid_1 = 1'b0; rf_data_valid_2 = 1'b0; rf_data_1 = '0; rf_data_2 = '0;
        resp_ready = 1'b0;

        //             vec     slot warp   rs1    rs2    en1   en2   d1 d2 st data1          data2          lat
        tbl[0] = '{4'b0100, 2, 5'd7,  5'd3,  5'd9,  1'b1, 1'b1, 2, 2, 0, 32'hA5A5_0001, 32'hA5A5_0002, 4};
        tbl[1] = '{4'b0001, 0, 5'd1,  5'd4,  5'd5,  1'b1, 1'b0, 1, 1, 0, 32'h0000_1234, 32'hDEAD_BEEF, 3};
        tbl[2] = '{4'b1010, 1, 5'd12, 5'd20, 5'd21, 1'b1, 1'b1, 6, 1, 3, 32'h1111_2222, 32'h3333_4444, 8};
        tbl[3] = '{4'b1000, 3, 5'd31, 5'd0,  5'd1,  1'b0, 1'b0, 1, 1, 0, 32'h5555_5555, 32'h6666_6666, 1};
        tbl[4] = '{4'b1111, 0, 5'd9,  5'd17, 5'd18, 1'b1, 1'b1, 3, 1, 1, 32'hCAFE_0001, 32'hCAFE_0002, 5};
        tbl[5] = '{4'b0101, 2, 5'd2,  5'd30, 5'd29, 1'b0, 1'b1, 1, 4, 0, 32'h7777_7777, 32'h0BAD_F00D, 6};

        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_vals("after_reset");

        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            t.vec   = 4'($urandom_range(1, 15));
            t.slot  = rr_pick(t.vec, mptr);
            t.warp  = 5'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom);
            t.en1   = 1'($urandom); t.en2 = 1'($urandom);
            t.d1    = $urandom_range(1, 6); t.d2 = $urandom_range(1, 6);
            t.stall = $urandom_range(0, 3);
            t.data1 = $urandom; t.data2 = $urandom;
            t.lat   = spec_latency(t.en1, t.en2, t.d1, t.d2);
            do_txn(t);
        end
        chk("no_err_after_clean_traffic", 32'(err), 32'd0);

        // Abort in WAIT: nothing leaks out, pointer returns to 0.
        t = '{4'b0100, 2, 5'd6, 5'd7, 5'd8, 1'b1, 1'b1, 1, 1, 0, 32'h0, 32'h0, 3};
        present(t);
        repeat (2) @(negedge clk);
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        mptr = 0;
        t = '{4'b1010, 1, 5'd11, 5'd13, 5'd14, 1'b1, 1'b1, 1, 2, 0, 32'hABCD_0001, 32'hABCD_0002, 4};
        do_txn(t);

        // Saturated requests with a zero-wait register file.
        do_reset();
        req_rs1_en = '1; req_rs2_en = '1; req_valid = '1; resp_ready = 1'b1;
        pv1 = 1'b0; pv2 = 1'b0; ng = 0;
        for (int k = 0; k < 18; k++) begin
            rf_data_valid_1 = pv1; rf_data_valid_2 = pv2;
            rf_data_1 = $urandom; rf_data_2 = $urandom;
            #1;
            if (req_ready != '0) begin
                if (ng < 8) begin
                    gcyc[ng] = k;
                    gidx[ng] = -1;
                    for (int j = 0; j < N; j++) if (req_ready[j]) gidx[ng] = j;
                end
                ng++;
            end
            pv1 = rf_req_1; pv2 = rf_req_2;
            @(negedge clk);
        end
        chk("rr_grant_count", 32'(ng), 32'd5);
        exp_slots = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5 && j < ng; j++) begin
            chk("rr_grant_slot", 32'(gidx[j]), 32'(exp_slots[j]));
            chk("rr_grant_cycle", 32'(gcyc[j]), 32'(4 * j));
        end
        req_valid = '0; rf_data_valid_1 = 1'b0; rf_data_valid_2 = 1'b0;

`ifdef RF_ARB_TIMEOUT_EN
        do_reset();
        t = '{4'b0001, 0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1, 1, 0, 32'h0, 32'h0, 17};
        present(t);
        begin
            int c;
            c = 0;
            @(negedge clk);
            req_valid = '0;
            c = 1;
            #1;
            while (!resp_valid && c < 40) begin
                @(negedge clk);
                c++;
                #1;
            end
            chk("timeout_resp_cycle", 32'(c), 32'd17);
            chk("timeout_err", 32'(err), 32'd1);
            chk("timeout_data_1", resp_data_1, 32'd0);
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
`endif

        // Read data outside WAIT is flagged and sticks.
        do_reset();
        #1;
        chk("pre_spurious_err", 32'(err), 32'd0);
        rf_data_valid_1 = 1'b1; rf_data_1 = 32'hFFFF_FFFF;
        @(negedge clk);
        rf_data_valid_1 = 1'b0;
        #1;
        chk("spurious_err", 32'(err), 32'd1);
        chk("spurious_no_resp", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Arbiter and sequencer for the shared warp-banked register-file read ports (two operand ports, 5-bit warp id, 5-bit register address, 32-bit data per port). It accepts operand-fetch requests from up to NUM_REQ issue slots and grants one per transaction in round-robin order. For the granted request it drives the register-file request/address lines, collects the variable-latency operand data, and returns both operands tagged with the requester index. It sits between the issue slots and the register file, replacing direct per-slot wiring of the read ports.

## Interface
- NUM_REQ, 4, number of requesting issue slots (2..8)
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-slot request pending
- req_ready  out  NUM_REQ  one-hot accept pulse; request consumed when valid&ready
- req_warp_id  in  NUM_REQ*5  per-slot warp id, slot i at [5i+4:5i]
- req_rs1, req_rs2  in  NUM_REQ*5 each  per-slot source register addresses
- req_rs1_en, req_rs2_en  in  NUM_REQ each  per-slot operand-needed flags
- rf_warp_id  out  5  warp id to register file
- rf_addr_1, rf_addr_2  out  5 each  read addresses
- rf_req_1, rf_req_2  out  1 each  single-cycle read request pulses
- rf_data_valid_1, rf_data_valid_2  in  1 each  read data valid
- rf_data_1, rf_data_2  in  32 each  read data
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  $clog2(NUM_REQ)  index of the requesting slot
- resp_data_1, resp_data_2  out  32 each  operands; 0 if not enabled or timed out
- err  out  1  sticky error flag, cleared only by reset

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If any req_valid is high, the round-robin arbiter picks the first valid slot at or after ptr, where ptr = last grant + 1 modulo NUM_REQ; ptr resets to 0.
  - The FSM pulses req_ready[g] for one cycle and latches warp id, rs1, rs2 and both enables for slot g.
  - Next state is ISSUE, or RESP if both enables are 0.
- **ISSUE**
  - The FSM drives rf_warp_id, rf_addr_x and rf_req_x = en_x for exactly one cycle, then goes to WAIT.
  - Disabled ports keep rf_req_x at 0.
- **WAIT**
  - A per-port done flag is pre-set when that port is disabled.
  - On rf_data_valid_x with done_x = 0, the FSM captures rf_data_x and sets done_x.
  - When both flags are set, the FSM moves to RESP.
  - Valid on the same cycle for both ports is captured together.
- **RESP**
  - resp_valid is held high and all resp_* outputs are held stable until resp_ready.
  - On resp_valid&resp_ready the FSM returns to IDLE; the next grant can occur in the cycle after that.
- **Error cases**
  - rf_data_valid_x seen while not in WAIT, or when done_x is already set, sets err. The data is ignored.
- **Slot behaviour**
  - A slot's req_valid may drop without penalty while not granted.
  - Fields are sampled only on the grant cycle.

## Timing
- Reset values:
  - FSM state IDLE.
  - req_ready, rf_req_1/2, resp_valid and err are 0.
  - rf_warp_id, rf_addr_1/2, resp_id and resp_data_1/2 are 0.
  - ptr is 0.
- Grant at cycle T: rf_req_x is high in T+1, and WAIT starts at T+2.
- Data captured at cycle C gives resp_valid at C+1.
- Minimum grant-to-grant spacing is 4 cycles (zero-wait register file, resp_ready held high).
- A request with both enables 0 gives resp_valid at T+1.
- Reset asserted mid-transaction aborts it immediately. No response is produced, and all outputs return to their reset values.
- resp_ready low stalls only RESP. Data arriving for a finished transaction sets err.

## Configuration
- RF_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT with any done_x still 0, the FSM sets err and goes to RESP.
  - Missing operands are returned as 0.
- RF_ARB_TIMEOUT_EN undefined:
  - No counter; WAIT waits indefinitely.
  - The TIMEOUT parameter is unused.

## Structure
- Package kiana_rf_pkg holds:
  - typedefs warp_id_t (logic [4:0]), reg_addr_t (logic [4:0]) and rf_data_t (logic [31:0]).
  - enum rf_arb_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module, rr_arbiter:
  - parameter N; inputs req[N-1:0], ptr, en; outputs one-hot gnt and gnt_idx.
  - It is purely combinational. ptr is updated in the parent.

## Test plan
- Slot 2 only, warp 7, rs1=3/en, rs2=9/en, both data valid 2 cycles after rf_req with 0xA5A5_0001/0xA5A5_0002 -> one rf_req pulse each with warp 7, addr 3/9; resp_id=2, data as given, err=0.
- All 4 slots valid continuously, zero-wait register file, resp_ready=1 -> grants in order 0,1,2,3,0, spaced 4 cycles apart.
- rs1_en=1, rs2_en=0; port 1 valid with 0x1234 -> rf_req_2 never high, resp_data_2=0, resp_data_1=0x1234.
- Port 2 data arrives 5 cycles before port 1, resp_ready held low 3 cycles -> both captured, resp outputs stable across the stall, single handshake.
- RF_ARB_TIMEOUT_EN, TIMEOUT=15, port 1 never valid -> err=1 after 15 WAIT cycles, resp_valid with resp_data_1=0. Separately, a spurious rf_data_valid_1 in IDLE -> err=1.
- rst_n asserted during WAIT -> all outputs return to their reset values and no response is produced. After release, a new request on slot 1 is granted first (ptr=0 and slot 0 idle).
